imem_loader: RTL
================

# imem_loader

Byte-stream program loader that fills the byte-based instruction memory before the core runs. It parses a framed byte stream (start byte, 16-bit length, payload, checksum) from a receiver such as a UART RX. It issues one byte write per payload byte at sequential addresses starting from 0, and holds the core in reset until a load has completed with a correct checksum.

## Interface
- N, 9, instruction memory address width in bytes (memory depth 2^N bytes)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid only while rx_valid=1
- rx_valid  in  1  single-cycle strobe, one per byte; may be high on consecutive cycles
- mem_we  out  1  byte write enable to instruction memory write port
- mem_addr  out  N  byte write address
- mem_wdata  out  8  byte write data
- cpu_hold  out  1  active-high core reset/hold request
- busy  out  1  high while a frame is being parsed (any state other than IDLE)
- done  out  1  one-cycle pulse: frame loaded, checksum correct
- err  out  1  one-cycle pulse: frame rejected

## Operation
- Frame format, all multi-byte fields big-endian: 0xA5, LEN_HI, LEN_LO, L payload bytes, CSUM.
- L = {LEN_HI, LEN_LO}. Valid range is 1..2^N. CSUM = 8-bit sum of payload bytes mod 256.
- Payload byte k (k = 0..L-1) is written to address k, so memory reads it back big-endian as instructions.
- Bytes are only consumed on cycles with rx_valid=1. All other cycles leave the state unchanged.
- FSM states:
  - IDLE: 0xA5 -> LEN_HI. Any other byte is ignored, with no err.
  - LEN_HI: store the byte -> LEN_LO.
  - LEN_LO: form L. If L=0 or L>2^N, pulse err -> IDLE. Otherwise clear the byte counter and running sum -> DATA.
  - DATA: write the byte at the counter address, add it to the sum, increment the counter. When the counter reaches L -> CSUM.
  - CSUM: byte equal to sum -> done pulse, cpu_hold<=0. Mismatch -> err pulse, cpu_hold unchanged. Either way -> IDLE.
- Internal widths: length and counter are N+1 bits, so L=2^N is representable. Running sum is 8 bits and wraps. mem_addr is counter[N-1:0].
- cpu_hold is 1 out of reset. It clears only on done.
  - A new 0xA5 header sets cpu_hold back to 1 on the cycle LEN_HI is entered. The core is held during any reload.
  - A failed frame leaves cpu_hold=1. Memory may hold a partial image.
- No timeout. A stalled frame waits indefinitely until rst.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, err=0; state IDLE; counter and sum 0.
- Reset in the middle of a frame aborts it immediately. No further writes occur, and the next byte is parsed from IDLE.
- All outputs are registered.
- Write latency:
  - A DATA byte sampled at edge t gives mem_we=1, mem_addr=k, mem_wdata=byte during the cycle after edge t.
  - mem_we is high for exactly that one cycle, unless the next byte is back-to-back.
- done/err latency: the pulse is high for the one cycle following the edge that samples the CSUM byte (or LEN_LO, for a bad length).
- cpu_hold timing: falls in the same cycle as done. Rises in the cycle after the 0xA5 edge.
- busy: high from the cycle after the 0xA5 edge through the cycle after the final byte's edge is excluded, i.e. it is low in the cycle done or err is high.
- Throughput: one byte per cycle. With back-to-back rx_valid, mem_we stays high and mem_addr increments every cycle.

## Test plan
- Reset: hold rst for 2 cycles with rx_valid toggling -> all outputs at reset values, cpu_hold=1, no mem_we.
- Good frame: stream A5 00 04 DE AD BE EF 38 back-to-back.
  - Writes (0,DE), (1,AD), (2,BE), (3,EF) on 4 consecutive cycles.
  - done is high for 1 cycle after the 0x38 edge, and cpu_hold goes to 0 in that same cycle.
- Bad checksum: same frame ending in 39 instead of 38 -> the 4 writes still occur, err pulses once, cpu_hold stays 1, done never asserts.
- Length bounds with N=9:
  - A5 00 00 -> err after LEN_LO, no writes.
  - A5 02 01 (513) -> err, no writes.
  - A5 02 00 with 512 bytes and the correct checksum -> last write to address 511, then done.
- Framing and gaps: send 00 FF 5A as noise, then the good frame with 3 idle cycles between bytes -> noise ignored, no err, writes identical to the good-frame case.
- Reload and abort:
  - After a successful load, send A5 -> cpu_hold returns to 1.
  - Assert rst after 2 payload bytes -> no more writes.
  - A fresh good frame then loads correctly starting at address 0.

Source files
------------

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the byte-wide instruction memory.
// Parses 0xA5 / LEN_HI / LEN_LO / payload / CSUM and holds the core until a clean load.
module imem_loader #(
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [7:0]   mem_wdata,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM} state_t;

  localparam logic [15:0] MAX_LEN = 16'(1) << N;
  localparam logic [N:0]  ONE     = (N+1)'(1);

  state_t     state;
  logic [7:0] len_hi;
  logic [N:0] len;
  logic [N:0] cnt;
  logic [7:0] sum;

  logic [15:0] len_word;
  logic [N:0]  cnt_inc;

  assign len_word = {len_hi, rx_data};
  assign cnt_inc  = cnt + ONE;

  // Lengths of zero or beyond the memory depth are rejected before any write.
  function automatic logic len_ok(input logic [15:0] l);
    return (l != 16'd0) && (l <= MAX_LEN);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_hi    <= '0;
      len       <= '0;
      cnt       <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == 8'hA5) begin
              state    <= LEN_HI;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
          LEN_HI: begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
          LEN_LO: begin
            if (len_ok(len_word)) begin
              len   <= len_word[N:0];
              cnt   <= '0;
              sum   <= '0;
              state <= DATA;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt[N-1:0];
            mem_wdata <= rx_data;
            sum       <= sum + rx_data;
            cnt       <= cnt_inc;
            if (cnt_inc == len) state <= CSUM;
          end
          CSUM: begin
            if (rx_data == sum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
